// File: rtl/olq_pkg.sv
// olq_pkg: node type and sizing helper shared by the open-list queue files.
package olq_pkg;
  localparam int DEF_F = 32;
  localparam int DEF_I = 16;
  localparam int DEF_J = 16;
  typedef struct packed {
    logic [DEF_F-1:0] f;
    logic [DEF_I-1:0] i;
    logic [DEF_J-1:0] j;
  } node_t;
  function automatic int cnt_w(input int q);
    return $clog2(q + 1);
  endfunction
endpackage

// File: rtl/olq_cell.sv
// olq_cell: one sorted-queue slot choosing hold, shift-up, shift-down or load-new each cycle.
module olq_cell
  import olq_pkg::*;
#(
  parameter int W = 64,
  parameter int FW = 32,
  parameter bit HEAD = 1'b0
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         wr,
  input  logic         rd,
  input  logic         lt_prev,
  input  logic         lt_next,
  input  logic         prev_occ,
  input  logic         next_occ,
  input  logic [W-1:0] prev_d,
  input  logic [W-1:0] next_d,
  input  logic [W-1:0] new_d,
  output logic         occ,
  output logic [W-1:0] d,
  output logic         lt
);
  logic         n_occ;
  logic [W-1:0] n_d;
  // lt: the new node belongs at or below this slot (strictly smaller f, or slot free)
  assign lt = !(occ && d[W-1 -: FW] <= new_d[W-1 -: FW]);
  always_comb begin
    n_d   = (rd && wr) ? (!lt_next ? next_d : ((HEAD || !lt) ? new_d : d))
          : rd ? next_d
          : (wr && lt) ? (lt_prev ? prev_d : new_d)
          : d;
    n_occ = (rd && wr) ? (!lt_next ? next_occ : ((HEAD || !lt) ? 1'b1 : occ))
          : rd ? next_occ
          : (wr && lt) ? (lt_prev ? prev_occ : 1'b1)
          : occ;
  end
  always_ff @(posedge CLK) begin
    if (RSTn) begin
      occ <= 1'b0;
      d   <= '0;
    end else begin
      occ <= n_occ;
      d   <= n_d;
    end
  end
endmodule

// File: rtl/open_list_queue.sv
// open_list_queue: min-f priority queue for the A* open list; one-cycle sorted insert and pop.
// Define OLQ_VALID_QUAL_EN to require i_valid=1 for requests to be accepted.
module open_list_queue
  import olq_pkg::*;
#(
  parameter int QUEUE_SIZE = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAP_WIDTH  = 16,
  parameter int MAP_HEIGHT = 16
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_wrt,
  input  logic                  i_read,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_node_f,
  input  logic [MAP_WIDTH-1:0]  i_node_i,
  input  logic [MAP_HEIGHT-1:0] i_node_j,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_node_f,
  output logic [MAP_WIDTH-1:0]  o_node_i,
  output logic [MAP_HEIGHT-1:0] o_node_j
);
  localparam int NW = DATA_WIDTH + MAP_WIDTH + MAP_HEIGHT;
  localparam int CW = cnt_w(QUEUE_SIZE);
`ifdef OLQ_VALID_QUAL_EN
  localparam bit QUAL = 1'b1;
`else
  localparam bit QUAL = 1'b0;
`endif
  logic [CW-1:0] cnt;
  logic          wr_acc, rd_acc;
  logic [NW-1:0] new_d;
  // index 0 and QUEUE_SIZE+1 are virtual neighbours beyond the ends of the queue
  logic [NW-1:0] val_x [QUEUE_SIZE+2];
  logic          occ_x [QUEUE_SIZE+2];
  logic          lt_x  [QUEUE_SIZE+2];
  assign o_empty = cnt == '0;
  assign o_full  = cnt == CW'(QUEUE_SIZE);
  assign rd_acc  = i_read && (i_valid || !QUAL) && !o_empty;
  assign wr_acc  = i_wrt && (i_valid || !QUAL) && (!o_full || rd_acc);
  assign new_d   = {i_node_f, i_node_i, i_node_j};
  assign val_x[0] = '0;
  assign occ_x[0] = 1'b0;
  assign lt_x[0]  = 1'b0;
  assign val_x[QUEUE_SIZE+1] = '0;
  assign occ_x[QUEUE_SIZE+1] = 1'b0;
  assign lt_x[QUEUE_SIZE+1]  = 1'b1;
  for (genvar k = 0; k < QUEUE_SIZE; k++) begin : g_cell
    olq_cell #(.W(NW), .FW(DATA_WIDTH), .HEAD(k == 0)) u_cell (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .wr       (wr_acc),
      .rd       (rd_acc),
      .lt_prev  (lt_x[k]),
      .lt_next  (lt_x[k+2]),
      .prev_occ (occ_x[k]),
      .next_occ (occ_x[k+2]),
      .prev_d   (val_x[k]),
      .next_d   (val_x[k+2]),
      .new_d    (new_d),
      .occ      (occ_x[k+1]),
      .d        (val_x[k+1]),
      .lt       (lt_x[k+1])
    );
  end
  always_ff @(posedge CLK) begin
    if (RSTn) begin
      cnt      <= '0;
      o_valid  <= 1'b0;
      o_node_f <= '0;
      o_node_i <= '0;
      o_node_j <= '0;
    end else begin
      cnt     <= cnt + CW'(wr_acc) - CW'(rd_acc);
      o_valid <= rd_acc;
      if (rd_acc) {o_node_f, o_node_i, o_node_j} <= val_x[1];
    end
  end
endmodule

// File: tb/tb_open_list_queue.sv
// tb_open_list_queue: directed vectors with hand-computed expectations for open_list_queue.
module tb_open_list_queue;
  import olq_pkg::*;
  logic        CLK = 1'b0;
  logic        RSTn = 1'b1;
  logic        i_wrt = 1'b0, i_read = 1'b0, i_valid = 1'b1;
  logic [31:0] i_node_f = '0;
  logic [15:0] i_node_i = '0, i_node_j = '0;
  logic        o_empty, o_full, o_valid;
  logic [31:0] o_node_f;
  logic [15:0] o_node_i, o_node_j;
  int checks = 0, errors = 0;
  node_t exp_q [10];
  always #5 CLK = ~CLK;
  open_list_queue dut (
    .CLK(CLK), .RSTn(RSTn), .i_wrt(i_wrt), .i_read(i_read), .i_valid(i_valid),
    .i_node_f(i_node_f), .i_node_i(i_node_i), .i_node_j(i_node_j),
    .o_empty(o_empty), .o_full(o_full), .o_valid(o_valid),
    .o_node_f(o_node_f), .o_node_i(o_node_i), .o_node_j(o_node_j)
  );
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic w, input logic r, input node_t n);
    i_wrt = w;
    i_read = r;
    {i_node_f, i_node_i, i_node_j} = n;
    @(posedge CLK);
    #1;
    i_wrt = 1'b0;
    i_read = 1'b0;
  endtask
  function automatic node_t nd(input int f, input int i, input int j);
    return node_t'({32'(f), 16'(i), 16'(j)});
  endfunction
  task automatic pop_chk(input string tag, input node_t n);
    cyc(1'b0, 1'b1, '0);
    chk(tag, {o_valid, o_node_f, o_node_i, o_node_j}, {1'b1, n});
  endtask
  initial begin
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b0;
    chk("reset", {o_empty, o_full, o_valid, o_node_f, o_node_i, o_node_j}, {3'b100, 64'h0});
    cyc(1'b1, 1'b0, nd(12, 5, 5));
    cyc(1'b1, 1'b0, nd(1, 3, 3));
    cyc(1'b1, 1'b0, nd(2, 1, 1));
    cyc(1'b1, 1'b0, nd(14, 6, 6));
    cyc(1'b1, 1'b0, nd(12, 4, 4));
    cyc(1'b1, 1'b0, nd(3, 2, 2));
    chk("six_flags", {o_empty, o_full}, 2'b00);
    pop_chk("sort0", nd(1, 3, 3));
    pop_chk("sort1", nd(2, 1, 1));
    pop_chk("sort2", nd(3, 2, 2));
    pop_chk("sort3", nd(12, 5, 5));
    pop_chk("sort4", nd(12, 4, 4));
    pop_chk("sort5", nd(14, 6, 6));
    chk("sort_empty", o_empty, 1'b1);
    cyc(1'b0, 1'b0, '0);
    chk("valid_drop", {o_valid, o_node_f}, {1'b0, 32'd14});
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b0, nd(9 - k, 9 - k, 7));
      chk("fill_full", o_full, k == 9);
    end
    cyc(1'b1, 1'b0, nd(20, 20, 20));
    chk("drop_full", {o_full, o_empty}, 2'b10);
    for (int k = 0; k < 10; k++) pop_chk("full_pop", nd(k, k, 7));
    chk("full_drained", {o_empty, o_full}, 2'b10);
    cyc(1'b0, 1'b1, '0);
    chk("empty_read", {o_valid, o_node_f, o_node_i, o_node_j}, {1'b0, nd(9, 9, 7)});
    cyc(1'b1, 1'b0, nd(5, 50, 0));
    cyc(1'b1, 1'b0, nd(7, 70, 0));
    cyc(1'b1, 1'b1, nd(3, 30, 0));
    chk("rw_pop", {o_valid, o_node_f, o_node_i, o_node_j, o_empty, o_full},
        {1'b1, nd(5, 50, 0), 2'b00});
    pop_chk("rw_q0", nd(3, 30, 0));
    pop_chk("rw_q1", nd(7, 70, 0));
    chk("rw_empty", o_empty, 1'b1);
    for (int k = 0; k < 10; k++) begin
      exp_q[k] = nd(k, k, 1);
      cyc(1'b1, 1'b0, exp_q[k]);
    end
    cyc(1'b1, 1'b1, nd(4, 99, 1));
    chk("rw_full", {o_valid, o_node_f, o_full}, {1'b1, 32'd0, 1'b1});
    for (int k = 0; k < 10; k++) begin
      node_t e;
      e = k < 4 ? exp_q[k + 1] : k == 4 ? nd(4, 99, 1) : exp_q[k];
      pop_chk("rw_full_pop", e);
    end
    chk("rw_full_empty", o_empty, 1'b1);
    cyc(1'b1, 1'b1, nd(8, 8, 8));
    chk("rw_on_empty", {o_valid, o_empty}, 2'b00);
    pop_chk("rw_on_empty_pop", nd(8, 8, 8));
    cyc(1'b1, 1'b0, nd(2, 2, 2));
    cyc(1'b1, 1'b0, nd(6, 6, 6));
    cyc(1'b0, 1'b1, '0);
    RSTn = 1'b1;
    cyc(1'b1, 1'b1, nd(1, 1, 1));
    RSTn = 1'b0;
    chk("mid_reset", {o_empty, o_full, o_valid, o_node_f}, {3'b100, 32'd0});
    i_valid = 1'b0;
    cyc(1'b1, 1'b0, nd(11, 11, 11));
    i_valid = 1'b1;
`ifdef OLQ_VALID_QUAL_EN
    chk("qual_off", o_empty, 1'b1);
`else
    chk("qual_off", o_empty, 1'b0);
    pop_chk("qual_off_pop", nd(11, 11, 11));
`endif
    cyc(1'b1, 1'b0, nd(13, 13, 13));
    chk("qual_on", o_empty, 1'b0);
    pop_chk("qual_on_pop", nd(13, 13, 13));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
